// File: rtl/tilelink_ul_arb_2m1s.sv
// Two-master, one-slave TileLink-UL arbiter with round-robin grant and one transaction in flight.
// Define TL_ARB_TIMEOUT_EN to add a D-channel timeout that returns an error response to the master.
module tilelink_ul_arb_2m1s #(
   parameter int TL_ADDR_WIDTH   = 64,
   parameter int TL_DATA_WIDTH   = 64,
   parameter int TL_STRB_WIDTH   = TL_DATA_WIDTH / 8,
   parameter int TL_SOURCE_WIDTH = 3,
   parameter int TL_SINK_WIDTH   = 3,
   parameter int TL_OPCODE_WIDTH = 3,
   parameter int TL_PARAM_WIDTH  = 3,
   parameter int TL_SIZE_WIDTH   = 8,
   parameter int TIMEOUT_CYCLES  = 255
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       m0_a_valid,
   input  logic [TL_OPCODE_WIDTH-1:0] m0_a_opcode,
   input  logic [TL_PARAM_WIDTH-1:0]  m0_a_param,
   input  logic [TL_ADDR_WIDTH-1:0]   m0_a_address,
   input  logic [TL_SIZE_WIDTH-1:0]   m0_a_size,
   input  logic [TL_STRB_WIDTH-1:0]   m0_a_mask,
   input  logic [TL_DATA_WIDTH-1:0]   m0_a_data,
   input  logic [TL_SOURCE_WIDTH-1:0] m0_a_source,
   output logic                       m0_a_ready,
   input  logic                       m1_a_valid,
   input  logic [TL_OPCODE_WIDTH-1:0] m1_a_opcode,
   input  logic [TL_PARAM_WIDTH-1:0]  m1_a_param,
   input  logic [TL_ADDR_WIDTH-1:0]   m1_a_address,
   input  logic [TL_SIZE_WIDTH-1:0]   m1_a_size,
   input  logic [TL_STRB_WIDTH-1:0]   m1_a_mask,
   input  logic [TL_DATA_WIDTH-1:0]   m1_a_data,
   input  logic [TL_SOURCE_WIDTH-1:0] m1_a_source,
   output logic                       m1_a_ready,
   output logic                       m0_d_valid,
   output logic [TL_OPCODE_WIDTH-1:0] m0_d_opcode,
   output logic [TL_PARAM_WIDTH-1:0]  m0_d_param,
   output logic [TL_SIZE_WIDTH-1:0]   m0_d_size,
   output logic [TL_SINK_WIDTH-1:0]   m0_d_sink,
   output logic [TL_SOURCE_WIDTH-1:0] m0_d_source,
   output logic [TL_DATA_WIDTH-1:0]   m0_d_data,
   output logic                       m0_d_error,
   input  logic                       m0_d_ready,
   output logic                       m1_d_valid,
   output logic [TL_OPCODE_WIDTH-1:0] m1_d_opcode,
   output logic [TL_PARAM_WIDTH-1:0]  m1_d_param,
   output logic [TL_SIZE_WIDTH-1:0]   m1_d_size,
   output logic [TL_SINK_WIDTH-1:0]   m1_d_sink,
   output logic [TL_SOURCE_WIDTH-1:0] m1_d_source,
   output logic [TL_DATA_WIDTH-1:0]   m1_d_data,
   output logic                       m1_d_error,
   input  logic                       m1_d_ready,
   output logic                       s_a_valid,
   output logic [TL_OPCODE_WIDTH-1:0] s_a_opcode,
   output logic [TL_PARAM_WIDTH-1:0]  s_a_param,
   output logic [TL_ADDR_WIDTH-1:0]   s_a_address,
   output logic [TL_SIZE_WIDTH-1:0]   s_a_size,
   output logic [TL_STRB_WIDTH-1:0]   s_a_mask,
   output logic [TL_DATA_WIDTH-1:0]   s_a_data,
   output logic [TL_SOURCE_WIDTH-1:0] s_a_source,
   input  logic                       s_a_ready,
   input  logic                       s_d_valid,
   input  logic [TL_OPCODE_WIDTH-1:0] s_d_opcode,
   input  logic [TL_PARAM_WIDTH-1:0]  s_d_param,
   input  logic [TL_SIZE_WIDTH-1:0]   s_d_size,
   input  logic [TL_SINK_WIDTH-1:0]   s_d_sink,
   input  logic [TL_SOURCE_WIDTH-1:0] s_d_source,
   input  logic [TL_DATA_WIDTH-1:0]   s_d_data,
   input  logic                       s_d_error,
   output logic                       s_d_ready,
   output logic                       grant_id,
   output logic                       busy,
   output logic                       timeout_pulse
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      A_XFER  = 2'd1,
      D_WAIT  = 2'd2
`ifdef TL_ARB_TIMEOUT_EN
      ,ERR_RSP = 2'd3
`endif
   } state_t;

   state_t state_q, state_d;
   logic   grant_q, grant_d;
   logic   ptr_q, ptr_d;

`ifdef TL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       pulse_q, pulse_d;
   logic [TL_OPCODE_WIDTH-1:0] cap_op_q, cap_op_d;
   logic [TL_SOURCE_WIDTH-1:0] cap_src_q, cap_src_d;
`endif

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
`ifdef TL_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
      pulse_d   = 1'b0;
      cap_op_d  = cap_op_q;
      cap_src_d = cap_src_q;
`endif
      case (state_q)
         IDLE: begin
            if (m0_a_valid || m1_a_valid) begin
               // Contention goes to the pointer; otherwise the lone requester wins.
               grant_d = (m0_a_valid && m1_a_valid) ? ptr_q : m1_a_valid;
               state_d = A_XFER;
            end
         end
         A_XFER: begin
            if (s_a_valid && s_a_ready) begin
               state_d = D_WAIT;
`ifdef TL_ARB_TIMEOUT_EN
               cnt_d     = '0;
               cap_op_d  = s_a_opcode;
               cap_src_d = s_a_source;
`endif
            end
         end
         D_WAIT: begin
            if (s_d_valid && s_d_ready) begin
               state_d = IDLE;
               ptr_d   = ~grant_q;
            end
`ifdef TL_ARB_TIMEOUT_EN
            else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                  state_d = ERR_RSP;
                  pulse_d = 1'b1;
               end
            end
`endif
         end
`ifdef TL_ARB_TIMEOUT_EN
         ERR_RSP: begin
            if (grant_q ? m1_d_ready : m0_d_ready) begin
               state_d = IDLE;
               ptr_d   = ~grant_q;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= 1'b0;
         ptr_q   <= 1'b0;
`ifdef TL_ARB_TIMEOUT_EN
         cnt_q   <= '0;
         pulse_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
`ifdef TL_ARB_TIMEOUT_EN
         cnt_q   <= cnt_d;
         pulse_q <= pulse_d;
`endif
      end
   end

`ifdef TL_ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      cap_op_q  <= cap_op_d;
      cap_src_q <= cap_src_d;
   end
   assign timeout_pulse = pulse_q;
`else
   assign timeout_pulse = 1'b0;
`endif

   assign grant_id = grant_q;
   assign busy     = (state_q != IDLE);

   // A-channel payload follows the grant; only valid/ready are state-gated.
   assign s_a_opcode  = grant_q ? m1_a_opcode  : m0_a_opcode;
   assign s_a_param   = grant_q ? m1_a_param   : m0_a_param;
   assign s_a_address = grant_q ? m1_a_address : m0_a_address;
   assign s_a_size    = grant_q ? m1_a_size    : m0_a_size;
   assign s_a_mask    = grant_q ? m1_a_mask    : m0_a_mask;
   assign s_a_data    = grant_q ? m1_a_data    : m0_a_data;
   assign s_a_source  = grant_q ? m1_a_source  : m0_a_source;

   always_comb begin
      s_a_valid   = 1'b0;
      s_d_ready   = 1'b0;
      m0_a_ready  = 1'b0;
      m1_a_ready  = 1'b0;
      m0_d_valid  = 1'b0;
      m1_d_valid  = 1'b0;
      m0_d_opcode = s_d_opcode;
      m0_d_param  = s_d_param;
      m0_d_size   = s_d_size;
      m0_d_sink   = s_d_sink;
      m0_d_source = s_d_source;
      m0_d_data   = s_d_data;
      m0_d_error  = s_d_error;
      m1_d_opcode = s_d_opcode;
      m1_d_param  = s_d_param;
      m1_d_size   = s_d_size;
      m1_d_sink   = s_d_sink;
      m1_d_source = s_d_source;
      m1_d_data   = s_d_data;
      m1_d_error  = s_d_error;
      case (state_q)
         IDLE: s_d_ready = 1'b1;
         A_XFER: begin
            s_a_valid = grant_q ? m1_a_valid : m0_a_valid;
            if (grant_q) m1_a_ready = s_a_ready;
            else         m0_a_ready = s_a_ready;
         end
         D_WAIT: begin
            if (grant_q) begin
               m1_d_valid = s_d_valid;
               s_d_ready  = m1_d_ready;
            end else begin
               m0_d_valid = s_d_valid;
               s_d_ready  = m0_d_ready;
            end
         end
`ifdef TL_ARB_TIMEOUT_EN
         ERR_RSP: begin
            if (grant_q) begin
               m1_d_valid  = 1'b1;
               m1_d_error  = 1'b1;
               m1_d_opcode = (cap_op_q == TL_OPCODE_WIDTH'(4)) ? TL_OPCODE_WIDTH'(1) : '0;
               m1_d_param  = '0;
               m1_d_size   = '0;
               m1_d_sink   = '0;
               m1_d_source = cap_src_q;
               m1_d_data   = '0;
            end else begin
               m0_d_valid  = 1'b1;
               m0_d_error  = 1'b1;
               m0_d_opcode = (cap_op_q == TL_OPCODE_WIDTH'(4)) ? TL_OPCODE_WIDTH'(1) : '0;
               m0_d_param  = '0;
               m0_d_size   = '0;
               m0_d_sink   = '0;
               m0_d_source = cap_src_q;
               m0_d_data   = '0;
            end
         end
`endif
         default: s_d_ready = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_tilelink_ul_arb_2m1s.sv
// Scoreboard bench for tilelink_ul_arb_2m1s: expected A requests and D responses are queued by
// the stimulus and popped by an independent monitor. Timeout scenario only with TL_ARB_TIMEOUT_EN.
module tb_tilelink_ul_arb_2m1s;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        m0_a_valid, m1_a_valid, m0_a_ready, m1_a_ready;
   logic [2:0]  m0_a_opcode, m0_a_param, m0_a_source, m1_a_opcode, m1_a_param, m1_a_source;
   logic [63:0] m0_a_address, m0_a_data, m1_a_address, m1_a_data;
   logic [7:0]  m0_a_size, m0_a_mask, m1_a_size, m1_a_mask;
   logic        m0_d_valid, m1_d_valid, m0_d_ready, m1_d_ready, m0_d_error, m1_d_error;
   logic [2:0]  m0_d_opcode, m0_d_param, m0_d_sink, m0_d_source;
   logic [2:0]  m1_d_opcode, m1_d_param, m1_d_sink, m1_d_source;
   logic [7:0]  m0_d_size, m1_d_size;
   logic [63:0] m0_d_data, m1_d_data;
   logic        s_a_valid, s_a_ready, s_d_valid, s_d_ready, s_d_error;
   logic [2:0]  s_a_opcode, s_a_param, s_a_source, s_d_opcode, s_d_param, s_d_sink, s_d_source;
   logic [63:0] s_a_address, s_a_data, s_d_data;
   logic [7:0]  s_a_size, s_a_mask, s_d_size;
   logic        grant_id, busy, timeout_pulse;

   tilelink_ul_arb_2m1s #(.TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .rst(rst),
      .m0_a_valid(m0_a_valid), .m0_a_opcode(m0_a_opcode), .m0_a_param(m0_a_param),
      .m0_a_address(m0_a_address), .m0_a_size(m0_a_size), .m0_a_mask(m0_a_mask),
      .m0_a_data(m0_a_data), .m0_a_source(m0_a_source), .m0_a_ready(m0_a_ready),
      .m1_a_valid(m1_a_valid), .m1_a_opcode(m1_a_opcode), .m1_a_param(m1_a_param),
      .m1_a_address(m1_a_address), .m1_a_size(m1_a_size), .m1_a_mask(m1_a_mask),
      .m1_a_data(m1_a_data), .m1_a_source(m1_a_source), .m1_a_ready(m1_a_ready),
      .m0_d_valid(m0_d_valid), .m0_d_opcode(m0_d_opcode), .m0_d_param(m0_d_param),
      .m0_d_size(m0_d_size), .m0_d_sink(m0_d_sink), .m0_d_source(m0_d_source),
      .m0_d_data(m0_d_data), .m0_d_error(m0_d_error), .m0_d_ready(m0_d_ready),
      .m1_d_valid(m1_d_valid), .m1_d_opcode(m1_d_opcode), .m1_d_param(m1_d_param),
      .m1_d_size(m1_d_size), .m1_d_sink(m1_d_sink), .m1_d_source(m1_d_source),
      .m1_d_data(m1_d_data), .m1_d_error(m1_d_error), .m1_d_ready(m1_d_ready),
      .s_a_valid(s_a_valid), .s_a_opcode(s_a_opcode), .s_a_param(s_a_param),
      .s_a_address(s_a_address), .s_a_size(s_a_size), .s_a_mask(s_a_mask),
      .s_a_data(s_a_data), .s_a_source(s_a_source), .s_a_ready(s_a_ready),
      .s_d_valid(s_d_valid), .s_d_opcode(s_d_opcode), .s_d_param(s_d_param),
      .s_d_size(s_d_size), .s_d_sink(s_d_sink), .s_d_source(s_d_source),
      .s_d_data(s_d_data), .s_d_error(s_d_error), .s_d_ready(s_d_ready),
      .grant_id(grant_id), .busy(busy), .timeout_pulse(timeout_pulse)
   );

   typedef struct packed {
      logic        g;
      logic [2:0]  op;
      logic [2:0]  src;
      logic [63:0] addr;
      logic [63:0] data;
   } exp_a_t;
   typedef struct packed {
      logic [2:0]  op;
      logic [2:0]  src;
      logic [63:0] data;
      logic        err;
   } exp_d_t;

   exp_a_t qa[$];
   exp_d_t qd0[$];
   exp_d_t qd1[$];
   int total = 0;
   int bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
      end
   endtask

   task automatic chk_d(input int m, input logic [2:0] op, input logic [2:0] src,
                        input logic [63:0] data, input logic err);
      exp_d_t e;
      if ((m == 0 && qd0.size() == 0) || (m == 1 && qd1.size() == 0)) begin
         total++;
         bad++;
         $display("FAIL d_unexpected_m%0d actual=beat required=none t=%0t", m, $time);
      end else begin
         e = (m == 0) ? qd0.pop_front() : qd1.pop_front();
         chk($sformatf("d%0d_opcode", m), {61'd0, op}, {61'd0, e.op});
         chk($sformatf("d%0d_source", m), {61'd0, src}, {61'd0, e.src});
         chk($sformatf("d%0d_data", m), data, e.data);
         chk($sformatf("d%0d_error", m), {63'd0, err}, {63'd0, e.err});
      end
   endtask

   // Monitor: pops expectations whenever a handshake is presented.
   always @(negedge clk) begin
      exp_a_t ea;
      if (!rst) begin
         if (s_a_valid && s_a_ready) begin
            if (qa.size() == 0) begin
               total++;
               bad++;
               $display("FAIL a_unexpected actual=request required=none t=%0t", $time);
            end else begin
               ea = qa.pop_front();
               chk("a_grant", {63'd0, grant_id}, {63'd0, ea.g});
               chk("a_opcode", {61'd0, s_a_opcode}, {61'd0, ea.op});
               chk("a_source", {61'd0, s_a_source}, {61'd0, ea.src});
               chk("a_address", s_a_address, ea.addr);
               chk("a_data", s_a_data, ea.data);
            end
         end
         if (m0_d_valid && m0_d_ready) chk_d(0, m0_d_opcode, m0_d_source, m0_d_data, m0_d_error);
         if (m1_d_valid && m1_d_ready) chk_d(1, m1_d_opcode, m1_d_source, m1_d_data, m1_d_error);
      end
   end

   task automatic send_a(input int m, input logic [2:0] op, input logic [63:0] addr,
                         input logic [2:0] src, input logic [63:0] data);
      @(posedge clk); #1;
      if (m == 0) begin
         m0_a_valid = 1'b1; m0_a_opcode = op; m0_a_address = addr; m0_a_source = src; m0_a_data = data;
      end else begin
         m1_a_valid = 1'b1; m1_a_opcode = op; m1_a_address = addr; m1_a_source = src; m1_a_data = data;
      end
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if ((m == 0) ? m0_a_ready : m1_a_ready) begin
            @(posedge clk); #1;
            if (m == 0) m0_a_valid = 1'b0; else m1_a_valid = 1'b0;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL a_ready_wait_m%0d actual=never_ready required=ready", m);
      if (m == 0) m0_a_valid = 1'b0; else m1_a_valid = 1'b0;
   endtask

   task automatic wait_a_hs();
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (s_a_valid && s_a_ready) begin
            @(posedge clk); #1;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL a_handshake_wait actual=none required=handshake");
   endtask

   task automatic slave_d(input logic [2:0] op, input logic [2:0] src, input logic [63:0] data,
                          input logic err);
      s_d_valid = 1'b1; s_d_opcode = op; s_d_source = src; s_d_data = data; s_d_error = err;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (s_d_ready) begin
            @(posedge clk); #1;
            s_d_valid = 1'b0;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL d_ready_wait actual=never_ready required=ready");
      s_d_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      m0_a_valid = 0; m0_a_opcode = 0; m0_a_param = 0; m0_a_address = 0; m0_a_size = 8'd3;
      m0_a_mask = 8'hFF; m0_a_data = 0; m0_a_source = 0;
      m1_a_valid = 0; m1_a_opcode = 0; m1_a_param = 0; m1_a_address = 0; m1_a_size = 8'd3;
      m1_a_mask = 8'hFF; m1_a_data = 0; m1_a_source = 0;
      m0_d_ready = 1'b1; m1_d_ready = 1'b1; s_a_ready = 1'b1;
      s_d_valid = 0; s_d_opcode = 0; s_d_param = 0; s_d_size = 8'd3; s_d_sink = 0;
      s_d_source = 0; s_d_data = 0; s_d_error = 0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_grant", {63'd0, grant_id}, 64'd0);
      chk("rst_m0_a_ready", {63'd0, m0_a_ready}, 64'd0);
      chk("rst_m1_a_ready", {63'd0, m1_a_ready}, 64'd0);
      chk("rst_m0_d_valid", {63'd0, m0_d_valid}, 64'd0);
      chk("rst_m1_d_valid", {63'd0, m1_d_valid}, 64'd0);
      chk("rst_s_a_valid", {63'd0, s_a_valid}, 64'd0);
      chk("rst_s_d_ready", {63'd0, s_d_ready}, 64'd1);
      chk("rst_timeout_pulse", {63'd0, timeout_pulse}, 64'd0);
      @(posedge clk); #1;

      // m0 Get -> AccessAckData 0xAB
      qa.push_back('{g: 1'b0, op: 3'd4, src: 3'd2, addr: 64'h10, data: 64'h0});
      qd0.push_back('{op: 3'd1, src: 3'd2, data: 64'hAB, err: 1'b0});
      fork
         send_a(0, 3'd4, 64'h10, 3'd2, 64'h0);
         begin
            wait_a_hs();
            slave_d(3'd1, 3'd2, 64'hAB, 1'b0);
         end
      join

      // Contention after an m0 grant: m1 first, then m0
      qa.push_back('{g: 1'b1, op: 3'd4, src: 3'd6, addr: 64'h30, data: 64'h0});
      qa.push_back('{g: 1'b0, op: 3'd0, src: 3'd1, addr: 64'h20, data: 64'h1111});
      qd1.push_back('{op: 3'd1, src: 3'd6, data: 64'hC0DE, err: 1'b0});
      qd0.push_back('{op: 3'd0, src: 3'd1, data: 64'h0, err: 1'b0});
      fork
         send_a(0, 3'd0, 64'h20, 3'd1, 64'h1111);
         send_a(1, 3'd4, 64'h30, 3'd6, 64'h0);
         begin
            wait_a_hs();
            slave_d(3'd1, 3'd6, 64'hC0DE, 1'b0);
            wait_a_hs();
            slave_d(3'd0, 3'd1, 64'h0, 1'b0);
         end
      join

      // Slave stalls A for 5 cycles; response carries an error through
      s_a_ready = 1'b0;
      qa.push_back('{g: 1'b0, op: 3'd4, src: 3'd3, addr: 64'h44, data: 64'h0});
      qd0.push_back('{op: 3'd1, src: 3'd3, data: 64'h77, err: 1'b1});
      fork
         send_a(0, 3'd4, 64'h44, 3'd3, 64'h0);
         begin
            @(posedge clk);
            @(posedge clk);
            for (int i = 0; i < 5; i++) begin
               @(negedge clk);
               chk("stall_m0_a_ready", {63'd0, m0_a_ready}, 64'd0);
               chk("stall_s_a_valid", {63'd0, s_a_valid}, 64'd1);
               chk("stall_s_a_address", s_a_address, 64'h44);
               chk("stall_s_a_source", {61'd0, s_a_source}, 64'd3);
            end
            @(posedge clk); #1;
            s_a_ready = 1'b1;
            wait_a_hs();
            slave_d(3'd1, 3'd3, 64'h77, 1'b1);
         end
      join

      // Reset during D_WAIT abandons the transaction; late beat is swallowed
      qa.push_back('{g: 1'b1, op: 3'd0, src: 3'd4, addr: 64'h50, data: 64'h55});
      fork
         send_a(1, 3'd0, 64'h50, 3'd4, 64'h55);
         wait_a_hs();
      join
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstmid_busy", {63'd0, busy}, 64'd0);
      chk("rstmid_grant", {63'd0, grant_id}, 64'd0);
      @(posedge clk); #1;
      s_d_valid = 1'b1; s_d_opcode = 3'd0; s_d_source = 3'd4; s_d_data = 64'hDEAD; s_d_error = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late_m0_d_valid", {63'd0, m0_d_valid}, 64'd0);
         chk("late_m1_d_valid", {63'd0, m1_d_valid}, 64'd0);
         chk("late_s_d_ready", {63'd0, s_d_ready}, 64'd1);
      end
      @(posedge clk); #1;
      s_d_valid = 1'b0;

      // Contention right after reset: m0 first, then m1
      qa.push_back('{g: 1'b0, op: 3'd4, src: 3'd0, addr: 64'h60, data: 64'h0});
      qa.push_back('{g: 1'b1, op: 3'd4, src: 3'd7, addr: 64'h70, data: 64'h0});
      qd0.push_back('{op: 3'd1, src: 3'd0, data: 64'h600, err: 1'b0});
      qd1.push_back('{op: 3'd1, src: 3'd7, data: 64'h700, err: 1'b0});
      fork
         send_a(0, 3'd4, 64'h60, 3'd0, 64'h0);
         send_a(1, 3'd4, 64'h70, 3'd7, 64'h0);
         begin
            wait_a_hs();
            slave_d(3'd1, 3'd0, 64'h600, 1'b0);
            wait_a_hs();
            slave_d(3'd1, 3'd7, 64'h700, 1'b0);
         end
      join

`ifdef TL_ARB_TIMEOUT_EN
      // Silent slave: error response to m1 after 8 D_WAIT cycles
      qa.push_back('{g: 1'b1, op: 3'd4, src: 3'd5, addr: 64'h80, data: 64'h0});
      qd1.push_back('{op: 3'd1, src: 3'd5, data: 64'h0, err: 1'b1});
      fork
         send_a(1, 3'd4, 64'h80, 3'd5, 64'h0);
         wait_a_hs();
      join
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("to_pulse_early", {63'd0, timeout_pulse}, 64'd0);
      end
      @(negedge clk);
      chk("to_pulse", {63'd0, timeout_pulse}, 64'd1);
      chk("to_m1_d_valid", {63'd0, m1_d_valid}, 64'd1);
      chk("to_m0_d_valid", {63'd0, m0_d_valid}, 64'd0);
      chk("to_s_d_ready", {63'd0, s_d_ready}, 64'd0);
      @(negedge clk);
      chk("to_pulse_clear", {63'd0, timeout_pulse}, 64'd0);
      chk("to_busy_clear", {63'd0, busy}, 64'd0);
`endif

      repeat (3) @(posedge clk);
      chk("qa_drained", 64'(qa.size()), 64'd0);
      chk("qd0_drained", 64'(qd0.size()), 64'd0);
      chk("qd1_drained", 64'(qd1.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
